// File: rtl/nes_controller_poller.sv
// NES game pad poller: drives latch/pulse, synchronises serial data, publishes 8 buttons as a 32-bit word.
// Optional NES_DEBOUNCE_EN: a poll result must repeat on two consecutive polls before it is published.
module nes_controller_poller #(
  parameter int HALF_CYCLES = 6000,
  parameter int POLL_GAP    = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nes_data,
  output logic        nes_latch,
  output logic        nes_pulse,
  output logic [31:0] controller_data,
  output logic        poll_done,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LATCH  = 3'd1,
    S_LOW    = 3'd2,
    S_HIGH   = 3'd3,
    S_UPDATE = 3'd4
  } state_t;

  localparam int CNT_MAX = (2 * HALF_CYCLES > POLL_GAP) ? 2 * HALF_CYCLES : POLL_GAP;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] GAP_LAST   = CW'(POLL_GAP - 1);
  localparam logic [CW-1:0] LATCH_LAST = CW'(2 * HALF_CYCLES - 1);
  localparam logic [CW-1:0] HALF_LAST  = CW'(HALF_CYCLES - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [1:0]    sync_q;
  logic [7:0]    shift;
`ifdef NES_DEBOUNCE_EN
  logic [7:0]    prev_raw;
`endif

  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      cnt             <= '0;
      bit_idx         <= 3'd0;
      nes_latch       <= 1'b0;
      nes_pulse       <= 1'b0;
      controller_data <= 32'd0;
      poll_done       <= 1'b0;
      sync_q          <= 2'b11;
      shift           <= 8'hFF;
`ifdef NES_DEBOUNCE_EN
      prev_raw        <= 8'hFF;
`endif
    end else begin
      sync_q    <= {sync_q[0], nes_data};
      poll_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cnt == GAP_LAST) begin
            cnt       <= '0;
            nes_latch <= 1'b1;
            state     <= S_LATCH;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_LATCH: begin
          if (cnt == LATCH_LAST) begin
            cnt       <= '0;
            nes_latch <= 1'b0;
            state     <= S_LOW;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_LOW: begin
          // Data has been stable for a whole half period here; sample at its end.
          if (cnt == HALF_LAST) begin
            cnt             <= '0;
            shift[bit_idx]  <= sync_q[1];
            if (bit_idx == 3'd7) begin
              state <= S_UPDATE;
            end else begin
              nes_pulse <= 1'b1;
              state     <= S_HIGH;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_HIGH: begin
          if (cnt == HALF_LAST) begin
            cnt       <= '0;
            nes_pulse <= 1'b0;
            bit_idx   <= bit_idx + 3'd1;
            state     <= S_LOW;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_UPDATE: begin
`ifdef NES_DEBOUNCE_EN
          if (shift == prev_raw) controller_data <= {24'd0, ~shift};
          prev_raw <= shift;
`else
          controller_data <= {24'd0, ~shift};
`endif
          poll_done <= 1'b1;
          bit_idx   <= 3'd0;
          cnt       <= '0;
          state     <= S_IDLE;
        end
        default: begin
          cnt     <= '0;
          bit_idx <= 3'd0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nes_controller_poller.sv
// Bench for nes_controller_poller: behavioural game pad, button-level expected model, directed and random polls.
module tb_nes_controller_poller;
  localparam int H   = 4;
  localparam int GAP = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        nes_data;
  logic        nes_latch;
  logic        nes_pulse;
  logic [31:0] controller_data;
  logic        poll_done;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  // Pad: latch loads the buttons, each pulse rising edge presents the next one (active-low).
  logic [7:0] buttons   = 8'h00;
  int         pad_idx   = 0;
  logic       force_en  = 1'b0;
  logic       force_val = 1'b1;

  // Reference: published word in pressed polarity, plus the previous raw poll for debounce.
  logic [7:0]  prev_pressed = 8'h00;
  logic [31:0] cd_model     = 32'd0;

  nes_controller_poller #(.HALF_CYCLES(H), .POLL_GAP(GAP)) dut (
    .clk             (clk),
    .rst             (rst),
    .nes_data        (nes_data),
    .nes_latch       (nes_latch),
    .nes_pulse       (nes_pulse),
    .controller_data (controller_data),
    .poll_done       (poll_done),
    .dbg_state       (dbg_state)
  );

  always #5 clk = ~clk;

  always @(posedge nes_latch) pad_idx = 0;
  always @(posedge nes_pulse) pad_idx = pad_idx + 1;
  assign nes_data = force_en ? force_val : ((pad_idx < 8) ? ~buttons[pad_idx] : 1'b0);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_poll(input logic [7:0] pressed);
`ifdef NES_DEBOUNCE_EN
    if (pressed == prev_pressed) cd_model = {24'd0, pressed};
    prev_pressed = pressed;
`else
    cd_model = {24'd0, pressed};
`endif
  endtask

  // mode 0: pad drives data; mode 1: forced pressed then released 3 cycles before bit-0 capture;
  // mode 2: released only 2 cycles before bit-0 capture (too late to be seen).
  task automatic run_poll(input int mode, input logic [7:0] pressed_exp);
    int   t;
    int   k;
    int   lat;
    int   pulses;
    int   pw;
    logic pp;
    if (mode != 0) begin
      force_en  = 1'b1;
      force_val = 1'b0;
    end
    t = 0;
    while (!nes_latch && t < GAP + 5) begin
      tick;
      t++;
      chk("idle_poll_done", poll_done, 1'b0);
    end
    chk("gap_cycles", t, GAP);
    lat = 1; pulses = 0; pw = 0; pp = 1'b0; k = 0;
    while (!poll_done && k < 100) begin
      tick;
      k++;
      if (mode == 1 && k == 9)  force_val = 1'b1;
      if (mode == 2 && k == 10) force_val = 1'b1;
      if (nes_latch) lat++;
      if (nes_pulse) begin
        if (!pp) pulses++;
        pw++;
      end else if (pp) begin
        chk("pulse_width", pw, H);
        pw = 0;
      end
      pp = nes_pulse;
    end
    chk("latch_cycles", lat, 2 * H);
    chk("pulse_count", pulses, 7);
    chk("done_latency", k, 17 * H + 1);
    model_poll(pressed_exp);
    chk("controller_data", controller_data, cd_model);
    force_en = 1'b0;
  endtask

  initial begin
    int t;
    logic [7:0] r;

    // Reset held three cycles.
    rst = 1'b1;
    repeat (3) begin
      tick;
      chk("rst_data", controller_data, 32'd0);
      chk("rst_latch", nes_latch, 1'b0);
      chk("rst_pulse", nes_pulse, 1'b0);
      chk("rst_done", poll_done, 1'b0);
    end
    rst = 1'b0;

    // A + Right pressed.
    buttons = 8'h81;
    run_poll(0, buttons);
    run_poll(0, buttons);

    // Pad released / disconnected.
    buttons = 8'h00;
    run_poll(0, buttons);
    run_poll(0, buttons);

    buttons = 8'h81;
    run_poll(0, buttons);
    run_poll(0, buttons);

    // Start + Up, reset during the HIGH phase of bit 3.
    buttons = 8'h18;
    t = 0;
    while (!nes_latch && t < GAP + 5) begin
      tick;
      t++;
    end
    chk("rstpoll_gap", t, GAP);
    repeat (37) tick;
    chk("rstpoll_pulse_high", nes_pulse, 1'b1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("midrst_latch", nes_latch, 1'b0);
    chk("midrst_pulse", nes_pulse, 1'b0);
    chk("midrst_data", controller_data, 32'd0);
    chk("midrst_done", poll_done, 1'b0);
    cd_model     = 32'd0;
    prev_pressed = 8'h00;
    run_poll(0, buttons);
    run_poll(0, buttons);

    // Synchroniser latency on the bit-0 capture.
    run_poll(2, 8'h01);
    run_poll(2, 8'h01);
    run_poll(1, 8'h00);
    run_poll(1, 8'h00);

    // B for one poll, then B for two consecutive polls.
    buttons = 8'h00; run_poll(0, buttons);
    buttons = 8'h02; run_poll(0, buttons);
    buttons = 8'h00; run_poll(0, buttons);
    buttons = 8'h02; run_poll(0, buttons);
    run_poll(0, buttons);

    // Random buttons, sometimes held across polls.
    for (int i = 0; i < 14; i++) begin
      r = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) buttons = r;
      run_poll(0, buttons);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
